// File: rtl/window_address_generator.sv
// window_address_generator: raster scan of KSIZE x KSIZE window tap addresses over an IMG_W x IMG_H image.
// Optional macro WINDOW_ADDR_FRAME_LOOP_EN: restart at base (0,0) after each frame instead of returning to IDLE.
`default_nettype none

module window_address_generator #(
  parameter int IMG_W  = 125,
  parameter int IMG_H  = 250,
  parameter int KSIZE  = 3,
  parameter int ADDR_W = 15,
  localparam int TW    = (KSIZE > 1) ? $clog2(KSIZE) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LOCKED,
  input  logic              start,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic [TW-1:0]     tap_col,
  output logic [TW-1:0]     tap_row,
  output logic              win_last,
  output logic              frame_last,
  output logic              busy,
  output logic              done
);

  localparam int BXW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int BYW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;

  localparam logic [TW-1:0]     c_K_MAX    = TW'(KSIZE - 1);
  localparam logic [BXW-1:0]    c_BX_MAX   = BXW'(IMG_W - KSIZE);
  localparam logic [BYW-1:0]    c_BY_MAX   = BYW'(IMG_H - KSIZE);
  localparam logic [ADDR_W-1:0] c_ROW      = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] c_BACK     = ADDR_W'((KSIZE - 1) * IMG_W - 1);
  localparam logic [ADDR_W-1:0] c_NEXT_ROW = ADDR_W'(KSIZE);
  localparam logic [ADDR_W-1:0] c_ONE      = ADDR_W'(1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_base;
  logic [TW-1:0]     r_tc;
  logic [TW-1:0]     r_tr;
  logic [BXW-1:0]    r_bx;
  logic [BYW-1:0]    r_by;
  logic              r_done;

  logic              w_run;
  logic              w_tr_end;
  logic              w_tc_end;
  logic              w_bx_end;
  logic              w_by_end;
  logic              w_win_end;
  logic              w_frame_end;
  logic [ADDR_W-1:0] w_base_next;

  assign w_run       = (r_state == c_RUN);
  assign w_tr_end    = (r_tr == c_K_MAX);
  assign w_tc_end    = (r_tc == c_K_MAX);
  assign w_bx_end    = (r_bx == c_BX_MAX);
  assign w_by_end    = (r_by == c_BY_MAX);
  assign w_win_end   = w_tr_end & w_tc_end;
  assign w_frame_end = w_win_end & w_bx_end & w_by_end;
  // Moving to the next row of windows skips the KSIZE-1 columns the kernel cannot start in.
  assign w_base_next = w_bx_end ? (r_base + c_NEXT_ROW) : (r_base + c_ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_IDLE;
      r_addr  <= '0;
      r_base  <= '0;
      r_tc    <= '0;
      r_tr    <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_done  <= 1'b0;
    end else if (LOCKED) begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state <= c_RUN;
            r_addr  <= '0;
            r_base  <= '0;
            r_tc    <= '0;
            r_tr    <= '0;
            r_bx    <= '0;
            r_by    <= '0;
          end
        end
        c_RUN: begin
          if (addr_ready) begin
            if (w_frame_end) begin
              r_done <= 1'b1;
              r_addr <= '0;
              r_base <= '0;
              r_tc   <= '0;
              r_tr   <= '0;
              r_bx   <= '0;
              r_by   <= '0;
`ifdef WINDOW_ADDR_FRAME_LOOP_EN
              r_state <= c_RUN;
`else
              r_state <= c_IDLE;
`endif
            end else if (w_tr_end) begin
              r_tr <= '0;
              if (w_tc_end) begin
                r_tc   <= '0;
                r_base <= w_base_next;
                r_addr <= w_base_next;
                if (w_bx_end) begin
                  r_bx <= '0;
                  r_by <= r_by + 1'b1;
                end else begin
                  r_bx <= r_bx + 1'b1;
                end
              end else begin
                // Back to the top row of the window, one column to the right.
                r_tc   <= r_tc + 1'b1;
                r_addr <= r_addr - c_BACK;
              end
            end else begin
              r_tr   <= r_tr + 1'b1;
              r_addr <= r_addr + c_ROW;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign addr       = r_addr;
  assign addr_valid = w_run;
  assign busy       = w_run;
  assign tap_col    = r_tc;
  assign tap_row    = r_tr;
  assign win_last   = w_run & w_win_end;
  assign frame_last = w_run & w_frame_end;
  assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_window_address_generator.sv
// Self-checking bench for window_address_generator: vector table, directed corner cases, random vs. scan model.
`default_nettype none

module tb_window_address_generator;

  localparam int IMG_W  = 5;
  localparam int IMG_H  = 4;
  localparam int KSIZE  = 3;
  localparam int ADDR_W = 8;
  localparam int TW     = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              LOCKED = 1'b1;
  logic              start = 1'b0;
  logic              addr_ready = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic              addr_valid;
  logic [TW-1:0]     tap_col;
  logic [TW-1:0]     tap_row;
  logic              win_last;
  logic              frame_last;
  logic              busy;
  logic              done;

  window_address_generator #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .KSIZE(KSIZE), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .LOCKED(LOCKED), .start(start), .addr_ready(addr_ready),
    .addr(addr), .addr_valid(addr_valid), .tap_col(tap_col), .tap_row(tap_row),
    .win_last(win_last), .frame_last(frame_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference scan order built from nested loops over window base and kernel position.
  typedef struct {
    int addr;
    int tc;
    int tr;
    bit wl;
    bit fl;
  } tap_t;
  tap_t q[$];

  task automatic build_model();
    tap_t t;
    for (int by = 0; by <= IMG_H - KSIZE; by++)
      for (int bx = 0; bx <= IMG_W - KSIZE; bx++)
        for (int tc = 0; tc < KSIZE; tc++)
          for (int tr = 0; tr < KSIZE; tr++) begin
            t.addr = (by + tr) * IMG_W + bx + tc;
            t.tc   = tc;
            t.tr   = tr;
            t.wl   = (tc == KSIZE - 1) && (tr == KSIZE - 1);
            t.fl   = t.wl && (bx == IMG_W - KSIZE) && (by == IMG_H - KSIZE);
            q.push_back(t);
          end
  endtask

  typedef struct {
    bit       st;
    bit       rdy;
    bit       lck;
    bit       valid;
    int       a;
    int       tc;
    int       tr;
    bit       wl;
  } vec_t;
  vec_t vt[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; addr_ready = 1'b0; LOCKED = 1'b1;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  function automatic longint pack_out();
    return {39'd0, addr_valid, 8'(addr), 8'(tap_col), 8'(tap_row), win_last};
  endfunction

  function automatic longint pack_exp(input bit v, input int a, input int tc, input int tr, input bit wl);
    return {39'd0, v, 8'(a), 8'(tc), 8'(tr), wl};
  endfunction

  initial begin
    int  cnt, last_a, idx, frames, cyc;
    bit  m_busy, m_done, xfer, seen_fl;

    build_model();

    // Reset state
    reset = 1'b0;
    #12;
    chk("reset_outputs", {addr_valid, busy, done, win_last, frame_last, 8'(addr), 8'(tap_col), 8'(tap_row)}, 0);
    reset = 1'b1;
    tick();
    chk("idle_no_valid", addr_valid, 0);

    // start, stall (ready=0), LOCKED low, ignored start in RUN, window boundary
    vt[0]  = '{1, 1, 1, 1,  0, 0, 0, 0};
    vt[1]  = '{0, 1, 1, 1,  5, 0, 1, 0};
    vt[2]  = '{0, 1, 1, 1, 10, 0, 2, 0};
    vt[3]  = '{0, 0, 1, 1, 10, 0, 2, 0};
    vt[4]  = '{0, 1, 0, 1, 10, 0, 2, 0};
    vt[5]  = '{0, 1, 1, 1,  1, 1, 0, 0};
    vt[6]  = '{1, 1, 1, 1,  6, 1, 1, 0};
    vt[7]  = '{0, 1, 1, 1, 11, 1, 2, 0};
    vt[8]  = '{0, 1, 1, 1,  2, 2, 0, 0};
    vt[9]  = '{0, 1, 1, 1,  7, 2, 1, 0};
    vt[10] = '{0, 1, 1, 1, 12, 2, 2, 1};
    vt[11] = '{0, 1, 1, 1,  1, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      start = vt[i].st; addr_ready = vt[i].rdy; LOCKED = vt[i].lck;
      tick();
      chk($sformatf("vec%0d", i), pack_out(), pack_exp(vt[i].valid, vt[i].a, vt[i].tc, vt[i].tr, vt[i].wl));
    end
    start = 1'b0; LOCKED = 1'b1;

    // Three-cycle stall mid-window, then LOCKED low for four cycles
    addr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", pack_out(), pack_exp(1, 1, 0, 0, 0));
    end
    addr_ready = 1'b1; LOCKED = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("locked_hold", pack_out(), pack_exp(1, 1, 0, 0, 0));
    end
    LOCKED = 1'b1;
    tick();
    chk("resume_tap", pack_out(), pack_exp(1, 6, 0, 1, 0));

    // Full frame with ready held high
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0; addr_ready = 1'b1;
    cnt = 0; last_a = -1; seen_fl = 0;
    for (int c = 0; c < 200 && !seen_fl; c++) begin
      if (addr_valid) begin
        if (cnt < q.size()) chk("frame_seq", addr, q[cnt].addr);
        cnt++;
        if (frame_last) begin
          seen_fl = 1; last_a = int'(addr);
        end
      end
      if (!seen_fl) begin
        chk("no_done_early", done, 0);
        tick();
      end
    end
    chk("frame_last_seen", seen_fl, 1);
    chk("frame_count", cnt, 54);
    chk("frame_last_addr", last_a, 19);
    tick();
    chk("done_pulse", done, 1);
`ifdef WINDOW_ADDR_FRAME_LOOP_EN
    chk("loop_busy", busy, 1);
    chk("loop_restart", pack_out(), pack_exp(1, 0, 0, 0, 0));
`else
    chk("end_idle", {addr_valid, busy}, 0);
`endif
    tick();
    chk("done_one_cycle", done, 0);

    // Reset mid-frame: asynchronous clear, no scan until a new start
    do_reset();
    start = 1'b1; tick(); start = 1'b0; addr_ready = 1'b1;
    repeat (7) tick();
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {addr_valid, busy, done, win_last, frame_last, 8'(addr), 8'(tap_col), 8'(tap_row)}, 0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_reset_idle", addr_valid, 0);
    end
    start = 1'b1; tick(); start = 1'b0;
    chk("rescan_from_0", pack_out(), pack_exp(1, 0, 0, 0, 0));

    // Random handshake/lock/start stimulus against the scan model
    do_reset();
    m_busy = 0; m_done = 0; idx = 0; frames = 0;
    for (cyc = 0; cyc < 4000 && frames < 4; cyc++) begin
      addr_ready = ($urandom_range(0, 9) < 7);
      LOCKED     = ($urandom_range(0, 9) < 9);
      start      = ($urandom_range(0, 7) == 0);
      xfer = m_busy && addr_ready && LOCKED;
      tick();
      if (LOCKED) begin
        m_done = 0;
        if (xfer) begin
          if (idx == q.size() - 1) begin
            m_done = 1; frames++; idx = 0;
`ifndef WINDOW_ADDR_FRAME_LOOP_EN
            m_busy = 0;
`endif
          end else begin
            idx++;
          end
        end else if (!m_busy && start) begin
          m_busy = 1; idx = 0;
        end
      end
      chk("rnd_ctrl", {addr_valid, busy, done}, {m_busy, m_busy, m_done});
      if (m_busy)
        chk("rnd_tap", {1'b0, 8'(addr), 8'(tap_col), 8'(tap_row), win_last, frame_last},
            {1'b0, 8'(q[idx].addr), 8'(q[idx].tc), 8'(q[idx].tr), q[idx].wl, q[idx].fl});
    end
    chk("rnd_frames_done", frames >= 4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
